// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the RV32I pipeline stall/flush controller.
// Split-transaction FSM states and the per-stage load-enable bundle.
package pipeline_ctrl_types;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        IWAIT_D = 2'd1,
        DWAIT_I = 2'd2
    } state_t;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } stage_en_t;

    localparam stage_en_t EN_ALL  = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1,
                                      exmem: 1'b1, memwb: 1'b1};
    localparam stage_en_t EN_NONE = '{pc: 1'b0, ifid: 1'b0, idex: 1'b0,
                                      exmem: 1'b0, memwb: 1'b0};
    localparam stage_en_t EN_LU   = '{pc: 1'b0, ifid: 1'b0, idex: 1'b0,
                                      exmem: 1'b1, memwb: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter used for pipeline stall statistics.
// Holds at all-ones once reached; cleared by the async active-low reset.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage RV32I pipeline.
// Merges split cache completions so each transaction advances the pipe once.
module pipeline_ctrl
    import pipeline_ctrl_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_stall,
    input  logic             br_mispredict,
    input  logic             icache_read,
    input  logic             icache_resp,
    input  logic             dcache_req,
    input  logic             dcache_resp,
    output logic             load_pc,
    output logic             redirect,
    output logic             ifetch_capture,
    output logic             load_ifid,
    output logic             load_idex,
    output logic             load_exmem,
    output logic             load_memwb,
    output logic             bubble_ifid,
    output logic             bubble_idex,
    output logic             bubble_exmem,
    output logic [CNT_W-1:0] cnt_loaduse,
    output logic [CNT_W-1:0] cnt_dstall,
    output logic [CNT_W-1:0] cnt_istall,
    output logic [CNT_W-1:0] cnt_flush
);

    state_t    state;
    logic      i_done;
    logic      d_done;
    logic      i_ok;
    logic      d_ok;
    logic      mem_ok;
    logic      i_hit;
    logic      d_hit;
    logic      c_frz;
    logic      c_lu;
    logic      c_fl;
    stage_en_t load;
    logic      bub_ifid;
    logic      bub_idex;
    logic      bub_exmem;
    logic      redir;
    logic      inc_loaduse;
    logic      inc_flush;
    logic      inc_dstall;
    logic      inc_istall;

    // A response only counts when its request is still asserted.
    assign i_hit  = icache_read & icache_resp;
    assign d_hit  = dcache_req & dcache_resp;
    assign i_ok   = !icache_read | icache_resp | i_done;
    assign d_ok   = !dcache_req | dcache_resp | d_done;
    assign mem_ok = i_ok & d_ok;

    assign c_frz = !mem_ok;
    assign c_lu  = mem_ok & forward_stall;
    assign c_fl  = mem_ok & !forward_stall & br_mispredict;

    always_comb begin
        load        = EN_ALL;
        bub_ifid    = 1'b0;
        bub_idex    = 1'b0;
        bub_exmem   = 1'b0;
        redir       = 1'b0;
        inc_loaduse = 1'b0;
        inc_flush   = 1'b0;
        unique case (1'b1)
            c_frz: begin
                load = EN_NONE;
            end
            c_lu: begin
                load        = EN_LU;
                bub_exmem   = 1'b1;
                inc_loaduse = 1'b1;
            end
            c_fl: begin
                redir     = 1'b1;
                bub_ifid  = 1'b1;
                bub_idex  = 1'b1;
                inc_flush = 1'b1;
            end
            default: begin
                load = EN_ALL;
            end
        endcase
    end

    assign inc_dstall = dcache_req & !d_ok;
    assign inc_istall = icache_read & !i_ok & d_ok;

    // Reset forces every stage to load a NOP.
    assign load_pc        = !rst | load.pc;
    assign load_ifid      = !rst | load.ifid;
    assign load_idex      = !rst | load.idex;
    assign load_exmem     = !rst | load.exmem;
    assign load_memwb     = !rst | load.memwb;
    assign bubble_ifid    = !rst | bub_ifid;
    assign bubble_idex    = !rst | bub_idex;
    assign bubble_exmem   = !rst | bub_exmem;
    assign redirect       = rst & redir;
    assign ifetch_capture = rst & icache_resp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            i_done <= 1'b0;
            d_done <= 1'b0;
        end else begin
            i_done <= !mem_ok & (i_done | i_hit);
            d_done <= !mem_ok & (d_done | d_hit);
            unique case (state)
                RUN: begin
                    if (i_hit && !d_ok) begin
                        state <= IWAIT_D;
                    end else if (d_hit && !i_ok) begin
                        state <= DWAIT_I;
                    end
                end
                IWAIT_D, DWAIT_I: begin
                    if (mem_ok) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_loaduse (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_loaduse),
        .count (cnt_loaduse)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_dstall (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_dstall),
        .count (cnt_dstall)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_istall (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_istall),
        .count (cnt_istall)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_flush),
        .count (cnt_flush)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Vector-table bench for pipeline_ctrl with a scoreboard queue.
// Narrow counters so saturation is reachable in a short run.
module tb_pipeline_ctrl;
    import pipeline_ctrl_types::*;

    localparam int W = 4;

    // {load_pc, redirect, capture, ifid, idex, exmem, memwb, b_ifid, b_idex, b_exmem}
    localparam logic [9:0] E_RUN = 10'b1001111000;
    localparam logic [9:0] CAP   = 10'b0010000000;
    localparam logic [9:0] E_FRZ = 10'b0000000000;
    localparam logic [9:0] E_LU  = 10'b0000011001;
    localparam logic [9:0] E_FL  = 10'b1101111110;
    localparam logic [9:0] E_RST = 10'b1001111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic forward_stall = 1'b0;
    logic br_mispredict = 1'b0;
    logic icache_read = 1'b0;
    logic icache_resp = 1'b0;
    logic dcache_req = 1'b0;
    logic dcache_resp = 1'b0;
    logic load_pc, redirect, ifetch_capture;
    logic load_ifid, load_idex, load_exmem, load_memwb;
    logic bubble_ifid, bubble_idex, bubble_exmem;
    logic [W-1:0] cnt_loaduse, cnt_dstall, cnt_istall, cnt_flush;

    pipeline_ctrl #(.CNT_W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .forward_stall  (forward_stall),
        .br_mispredict  (br_mispredict),
        .icache_read    (icache_read),
        .icache_resp    (icache_resp),
        .dcache_req     (dcache_req),
        .dcache_resp    (dcache_resp),
        .load_pc        (load_pc),
        .redirect       (redirect),
        .ifetch_capture (ifetch_capture),
        .load_ifid      (load_ifid),
        .load_idex      (load_idex),
        .load_exmem     (load_exmem),
        .load_memwb     (load_memwb),
        .bubble_ifid    (bubble_ifid),
        .bubble_idex    (bubble_idex),
        .bubble_exmem   (bubble_exmem),
        .cnt_loaduse    (cnt_loaduse),
        .cnt_dstall     (cnt_dstall),
        .cnt_istall     (cnt_istall),
        .cnt_flush      (cnt_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] in;
        logic [9:0] ex;
        state_t     st;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] ex;
        state_t     st;
        logic [W-1:0] lu, ds, is, fl;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic m_i, m_d;
    logic [W-1:0] m_lu, m_ds, m_is, m_fl;

    function automatic logic [9:0] outs();
        return {load_pc, redirect, ifetch_capture, load_ifid, load_idex,
                load_exmem, load_memwb, bubble_ifid, bubble_idex, bubble_exmem};
    endfunction

    function automatic logic [W-1:0] sat(input logic [W-1:0] c, input logic inc);
        return (inc && c != {W{1'b1}}) ? c + W'(1) : c;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input string n, input logic [5:0] in,
                       input logic [9:0] ex, input state_t st, input int reps);
        vec_t v;
        v.name = n;
        v.in   = in;
        v.ex   = ex;
        v.st   = st;
        for (int i = 0; i < reps; i++) tbl.push_back(v);
    endtask

    task automatic drive(input logic [5:0] in);
        {forward_stall, br_mispredict, icache_read, icache_resp,
         dcache_req, dcache_resp} = in;
    endtask

    task automatic model_reset();
        m_i  = 1'b0;
        m_d  = 1'b0;
        m_lu = '0;
        m_ds = '0;
        m_is = '0;
        m_fl = '0;
    endtask

    task automatic model_update(input logic [5:0] in);
        logic fs, bm, ir, irsp, dr, drsp, i_ok, d_ok, ok;
        {fs, bm, ir, irsp, dr, drsp} = in;
        i_ok = !ir | irsp | m_i;
        d_ok = !dr | drsp | m_d;
        ok   = i_ok & d_ok;
        m_ds = sat(m_ds, dr & !d_ok);
        m_is = sat(m_is, ir & !i_ok & d_ok);
        m_lu = sat(m_lu, ok & fs);
        m_fl = sat(m_fl, ok & !fs & bm);
        m_i  = !ok & (m_i | (ir & irsp));
        m_d  = !ok & (m_d | (dr & drsp));
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        exp_t g;
        @(posedge clk);
        #1;
        drive(v.in);
        e.name = v.name;
        e.ex   = v.ex;
        e.st   = v.st;
        e.lu   = m_lu;
        e.ds   = m_ds;
        e.is   = m_is;
        e.fl   = m_fl;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        check({g.name, ".outs"}, 32'(outs()), 32'(g.ex));
        check({g.name, ".state"}, 32'(dut.state), 32'(g.st));
        check({g.name, ".cnt_loaduse"}, 32'(cnt_loaduse), 32'(g.lu));
        check({g.name, ".cnt_dstall"}, 32'(cnt_dstall), 32'(g.ds));
        check({g.name, ".cnt_istall"}, 32'(cnt_istall), 32'(g.is));
        check({g.name, ".cnt_flush"}, 32'(cnt_flush), 32'(g.fl));
        model_update(v.in);
    endtask

    task automatic chk_reset(input string nm);
        check({nm, ".outs"}, 32'(outs()), 32'(E_RST));
        check({nm, ".state"}, 32'(dut.state), 32'(RUN));
        check({nm, ".cnts"}, 32'({cnt_loaduse, cnt_dstall, cnt_istall, cnt_flush}), 32'(0));
    endtask

    initial begin
        int seg_a;
        // input order {fs, bm, ir, irsp, dr, drsp}
        add("idle",      6'b001100, E_RUN | CAP, RUN, 4);
        add("lu",        6'b101111, E_LU | CAP,  RUN, 1);
        add("lu_after",  6'b001111, E_RUN | CAP, RUN, 1);
        add("split_c0",  6'b000000, E_RUN,       RUN, 1);
        add("split_c1",  6'b001010, E_FRZ,       RUN, 1);
        add("split_c2",  6'b001110, E_FRZ | CAP, RUN, 1);
        add("split_c3",  6'b001010, E_FRZ,       IWAIT_D, 2);
        add("split_c5",  6'b001011, E_RUN,       IWAIT_D, 1);
        add("split_c6",  6'b001010, E_FRZ,       RUN, 1);
        add("split_c7",  6'b001111, E_RUN | CAP, RUN, 1);
        add("bm_dmiss",  6'b010010, E_FRZ,       RUN, 3);
        add("bm_dresp",  6'b010011, E_FL,        RUN, 1);
        add("bm_after",  6'b000000, E_RUN,       RUN, 1);
        add("lu_bm",     6'b111111, E_LU | CAP,  RUN, 1);
        add("lu_bm_aft", 6'b001111, E_RUN | CAP, RUN, 1);
        add("dw_resp",   6'b001011, E_FRZ,       RUN, 1);
        add("dw_hold",   6'b001010, E_FRZ,       DWAIT_I, 1);
        add("dw_iresp",  6'b001110, E_RUN | CAP, DWAIT_I, 1);
        add("rst_arm",   6'b001011, E_FRZ,       RUN, 1);
        seg_a = tbl.size();
        add("stray_i",   6'b000100, E_RUN | CAP, RUN, 1);
        add("stray_d",   6'b000001, E_RUN,       RUN, 1);
        add("post_rst",  6'b001111, E_RUN | CAP, RUN, 1);
        add("sat_lu",    6'b101111, E_LU | CAP,  RUN, 20);

        model_reset();
        drive(6'b001111);
        #1 rst = 1'b0;
        #2 chk_reset("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(6'b000000);

        for (int i = 0; i < seg_a; i++) step(tbl[i]);

        @(posedge clk);
        #1 drive(6'b001110);
        @(negedge clk);
        check("pre_rst.state", 32'(dut.state), 32'(DWAIT_I));
        #2 rst = 1'b0;
        #1 chk_reset("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        drive(6'b000000);
        model_reset();

        for (int i = seg_a; i < tbl.size(); i++) step(tbl[i]);
        check("sat_hold", 32'(cnt_loaduse), 32'({W{1'b1}}));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32I pipeline.
- Consumes the forwarding unit's load-use stall request, EX-stage branch mispredict, and the I-cache/D-cache request/response handshakes.
- Produces per-stage pipeline-register load enables, bubble-insert controls and PC redirect enable.
- Tracks split-transaction cache completion so that responses arriving in different cycles advance the pipeline exactly once, and keeps stall performance counters.

Parameters:
- CNT_W, 32, width of each saturating performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- forward_stall  in  1  load-use hazard: ID/EX consumer depends on EX/MEM load
- br_mispredict  in  1  EX-stage control-flow mispredict (redirect target supplied to pcmux elsewhere)
- icache_read  in  1  fetch request asserted
- icache_resp  in  1  one-cycle fetch completion pulse
- dcache_req  in  1  MEM-stage load/store request asserted
- dcache_resp  in  1  one-cycle data completion pulse
- load_pc  out  1  PC register enable
- redirect  out  1  select mispredict target into PC (only with load_pc)
- ifetch_capture  out  1  fetch buffer latches the returning instruction word
- load_ifid, load_idex, load_exmem, load_memwb  out  1 each  stage register enables
- bubble_ifid, bubble_idex, bubble_exmem  out  1 each  load a NOP into that stage register (qualified by its load_*)
- cnt_loaduse, cnt_dstall, cnt_istall, cnt_flush  out  CNT_W each  saturating event counters

Behaviour:
- Reset (rst low, async): state=RUN, i_done=d_done=0, all counters 0.
  - Outputs while in reset: load_* = 1, bubble_* = 1, redirect = 0, ifetch_capture = 0. This flushes the pipeline to NOPs.
- Completion latches:
  - i_ok = !icache_read | icache_resp | i_done.
  - d_ok = !dcache_req | dcache_resp | d_done.
  - mem_ok = i_ok & d_ok.
- i_done / d_done:
  - Set when the resp pulse arrives while mem_ok=0.
  - Cleared in the cycle the pipeline advances (mem_ok=1).
  - Never set in RUN when both responses arrive together.
- ifetch_capture = icache_resp (fetch buffer holds the word until load_ifid).
- FSM states:
  - RUN: no outstanding completion latched.
  - IWAIT_D: instruction returned, data outstanding.
  - DWAIT_I: data returned, instruction outstanding.
- FSM transitions:
  - RUN -> IWAIT_D on icache_resp & !d_ok.
  - RUN -> DWAIT_I on dcache_resp & !i_ok.
  - Either wait state -> RUN when the other response arrives.
  - No transition when neither or both responses arrive.
- Priority each cycle (first match wins):
  1. mem_ok=0: all load_* = 0, load_pc = 0. Mispredict and load-use are held by the frozen registers; no counter except istall/dstall increments.
  2. forward_stall=1: load_pc = load_ifid = load_idex = 0; load_exmem = 1 with bubble_exmem = 1; load_memwb = 1. br_mispredict is ignored this cycle because branch operands are not yet valid.
  3. br_mispredict=1: load_pc = redirect = 1; all load_* = 1; bubble_ifid = bubble_idex = 1.
  4. Otherwise all enables = 1 and all bubbles = 0.
- Counters increment by 1 per cycle and saturate at all-ones:
  - cnt_dstall: dcache_req & !d_ok.
  - cnt_istall: icache_read & !i_ok & d_ok.
  - cnt_loaduse: case 2.
  - cnt_flush: case 3.
- Combinational outputs depend on current inputs plus the registered latches only. No output-to-input combinational loops are permitted.
- Reset asserted mid-stall discards the latches; any in-flight response arriving after reset release with no request is ignored.

Decomposition:
- Add a pipeline_ctrl_types package holding the FSM state enum (RUN, IWAIT_D, DWAIT_I) and a stage-enable struct {pc, ifid, idex, exmem, memwb}.
- One sub-module, sat_counter (parameter CNT_W; ports clk, rst, inc, count), instantiated four times.

Test Plan:
1. Reset then idle: icache_read=1, icache_resp every cycle, dcache_req=0 -> all load_* = 1, bubble_* = 0, counters stay 0.
2. Load-use: forward_stall=1 for one cycle with both caches hitting -> that cycle load_pc = load_ifid = load_idex = 0, bubble_exmem = 1; cnt_loaduse = 1; next cycle all enables = 1.
3. Split responses: dcache_req=1 with resp at cycle 5; icache_read=1 with resp at cycle 2 -> FSM enters IWAIT_D at cycle 2 and ifetch_capture = 1 at cycle 2 only; enables stay 0 through cycle 4 and assert at cycle 5; cnt_dstall = 4; no second advance at cycle 6 without new responses.
4. Mispredict during D-miss: br_mispredict=1 held with dcache_resp at cycle 3 -> no redirect at cycles 0-2; at cycle 3 redirect = 1 and bubble_ifid = bubble_idex = 1; cnt_flush = 1.
5. forward_stall and br_mispredict together -> load-use behaviour only, redirect = 0; cnt_flush unchanged.
6. Async reset asserted in DWAIT_I mid-cycle -> state RUN immediately; latches and counters 0; bubble_* = 1 while rst is low. Separately, force a counter to all-ones -> it holds at all-ones.
